// File: rtl/kernel_nios2_div_pkg.sv
// Shared types and constants for the Nios II iterative divider.
//   div_state_t   : controller states (IDLE, DIV, FIX)
//   DIV_W         : operand/result width
//   DIV_ITER      : restoring steps per division (one quotient bit each)
//   DIV_LATENCY   : enabled cycles from start cycle to done cycle
//   DIV_ZERO_QUOT : quotient returned for a zero divisor
package kernel_nios2_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } div_state_t;

  localparam int DIV_W       = 32;
  localparam int DIV_ITER    = 32;
  localparam int DIV_LATENCY = 34;
  localparam logic [DIV_W-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/kernel_nios2_cpu_div_step.sv
// One combinational radix-2 restoring division step.
//   rem      in  DATA_W+1  partial remainder
//   dvd      in  DATA_W    dividend bits still to shift in (low end collects quotient)
//   divisor  in  DATA_W    divisor magnitude
//   rem_nxt  out DATA_W+1  partial remainder after the step
//   dvd_nxt  out DATA_W    dvd shifted left with the new quotient bit appended
//   q_bit    out 1         quotient bit produced by this step
module kernel_nios2_cpu_div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W:0]   rem,
  input  logic [DATA_W-1:0] dvd,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W:0]   rem_nxt,
  output logic [DATA_W-1:0] dvd_nxt,
  output logic              q_bit
);

  logic [DATA_W+1:0] rem_sh;
  logic [DATA_W:0]   trial;

  always_comb begin
    // {rem, dvd} << 1: the dividend MSB enters the remainder
    rem_sh  = {rem, dvd[DATA_W-1]};
    // Full-width compare decides the bit; the subtraction only needs DATA_W+1
    // bits because the result is kept only when it is non-negative.
    q_bit   = (rem_sh >= {2'b00, divisor});
    trial   = rem_sh[DATA_W:0] - {1'b0, divisor};
    rem_nxt = q_bit ? trial : rem_sh[DATA_W:0];
    dvd_nxt = {dvd[DATA_W-2:0], q_bit};
  end

endmodule

// File: rtl/kernel_nios2_cpu_div_cell.sv
// Iterative 32-bit signed/unsigned divider for the kernel Nios II CPU.
// Start is accepted in IDLE with M_en=1; 32 restoring steps (DIV) follow,
// then one FIX cycle applies signs and registers the result with a done pulse.
//   clk          in   clock, rising edge
//   reset_n      in   synchronous active-low reset
//   M_en         in   pipeline enable; low freezes all state
//   E_src1       in   dividend
//   E_src2       in   divisor
//   E_div_start  in   start request
//   E_div_signed in   1 = signed divide, 0 = unsigned
//   M_div_busy   out  operation in progress
//   M_div_done   out  one-cycle (enabled) result strobe
//   M_div_quot   out  quotient, held until the next result
//   M_div_rem    out  remainder (only when KERNEL_DIV_REM_EN is defined)
// Optional build macro: KERNEL_DIV_REM_EN
module kernel_nios2_cpu_div_cell
  import kernel_nios2_div_pkg::*;
#(
  parameter int DATA_W = DIV_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              M_en,
  input  logic [DATA_W-1:0] E_src1,
  input  logic [DATA_W-1:0] E_src2,
  input  logic              E_div_start,
  input  logic              E_div_signed,
  output logic              M_div_busy,
  output logic              M_div_done,
  output logic [DATA_W-1:0] M_div_quot
`ifdef KERNEL_DIV_REM_EN
  ,
  output logic [DATA_W-1:0] M_div_rem
`endif
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITER - 1);

  div_state_t        state;
  logic [4:0]        cnt;
  logic [DATA_W:0]   rem;
  logic [DATA_W-1:0] dvd;
  logic [DATA_W-1:0] dvsr;
  logic              q_neg;
  logic              dvsr_zero;
`ifdef KERNEL_DIV_REM_EN
  logic              r_neg;
`endif

  logic [DATA_W:0]   rem_nxt;
  logic [DATA_W-1:0] dvd_nxt;
  logic              q_bit;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v,
                                            input logic sgn);
    logic signed [DATA_W-1:0] v_s;
    v_s = $signed(v);
    return (sgn && v_s < 0) ? DATA_W'(-v_s) : v;
  endfunction

  // Two's-complement negate modulo 2^DATA_W when neg is set
  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic neg);
    return neg ? DATA_W'(-$signed(v)) : v;
  endfunction

  kernel_nios2_cpu_div_step #(.DATA_W(DATA_W)) u_step (
    .rem     (rem),
    .dvd     (dvd),
    .divisor (dvsr),
    .rem_nxt (rem_nxt),
    .dvd_nxt (dvd_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      rem        <= '0;
      dvd        <= '0;
      dvsr       <= '0;
      q_neg      <= 1'b0;
      dvsr_zero  <= 1'b0;
      M_div_busy <= 1'b0;
      M_div_done <= 1'b0;
      M_div_quot <= '0;
`ifdef KERNEL_DIV_REM_EN
      r_neg      <= 1'b0;
      M_div_rem  <= '0;
`endif
    end else if (M_en) begin
      case (state)
        IDLE: begin
          M_div_done <= 1'b0;
          if (E_div_start) begin
            dvd        <= mag(E_src1, E_div_signed);
            dvsr       <= mag(E_src2, E_div_signed);
            q_neg      <= E_div_signed & (E_src1[DATA_W-1] ^ E_src2[DATA_W-1]);
            dvsr_zero  <= (E_src2 == '0);
`ifdef KERNEL_DIV_REM_EN
            r_neg      <= E_div_signed & E_src1[DATA_W-1];
`endif
            rem        <= '0;
            cnt        <= '0;
            M_div_busy <= 1'b1;
            state      <= DIV;
          end
        end
        // ---- DIV: one quotient bit per enabled cycle ----
        DIV: begin
          rem <= rem_nxt;
          dvd <= dvd_nxt;
          cnt <= cnt + 5'd1;
          if (cnt == LAST_ITER) state <= FIX;
        end
        // ---- FIX: sign correction and result registration ----
        FIX: begin
          M_div_quot <= dvsr_zero ? DIV_ZERO_QUOT : cond_neg(dvd, q_neg);
`ifdef KERNEL_DIV_REM_EN
          // With a zero divisor every step subtracts nothing, so the
          // remainder already equals the original dividend after sign fix.
          M_div_rem  <= cond_neg(rem[DATA_W-1:0], r_neg);
`endif
          M_div_done <= 1'b1;
          M_div_busy <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_nios2_cpu_div_cell.sv
// Self-checking bench for kernel_nios2_cpu_div_cell: directed cases plus
// randomized operands against a plain-arithmetic reference model.
module tb_kernel_nios2_cpu_div_cell;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        M_en = 1'b1;
  logic [31:0] E_src1 = '0;
  logic [31:0] E_src2 = '0;
  logic        E_div_start = 1'b0;
  logic        E_div_signed = 1'b0;
  logic        M_div_busy;
  logic        M_div_done;
  logic [31:0] M_div_quot;
`ifdef KERNEL_DIV_REM_EN
  logic [31:0] M_div_rem;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  kernel_nios2_cpu_div_cell dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .M_en         (M_en),
    .E_src1       (E_src1),
    .E_src2       (E_src2),
    .E_div_start  (E_div_start),
    .E_div_signed (E_div_signed),
    .M_div_busy   (M_div_busy),
    .M_div_done   (M_div_done),
    .M_div_quot   (M_div_quot)
`ifdef KERNEL_DIV_REM_EN
    ,
    .M_div_rem    (M_div_rem)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_rem(input string tag, input logic [31:0] exp);
`ifdef KERNEL_DIV_REM_EN
    chk(tag, M_div_rem, exp);
`else
    chk(tag, 32'(M_div_done), 32'(M_div_done || (exp != exp)));
`endif
  endtask

  // C-style truncating division; remainder takes the dividend's sign.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  input logic sgn,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Issue one division with M_en high; return cycles to done and busy count.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                        output int lat, output int bcnt);
    E_src1       = a;
    E_src2       = b;
    E_div_signed = sgn;
    E_div_start  = 1'b1;
    lat  = 0;
    bcnt = 0;
    do begin
      tick();
      E_div_start = 1'b0;
      lat++;
      if (M_div_busy) bcnt++;
    end while (!M_div_done && lat < 100);
  endtask

  initial begin
    int lat, bcnt, held_bad, done_seen;
    logic [31:0] a, b, eq, er;
    logic sgn;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", 32'(M_div_busy), 32'd0);
    chk("rst_done", 32'(M_div_done), 32'd0);
    chk("rst_quot", M_div_quot, 32'd0);
    chk_rem("rst_rem", 32'd0);
    reset_n = 1'b1;
    tick();

    // Unsigned 100 / 7
    do_div(32'd100, 32'd7, 1'b0, lat, bcnt);
    chk("u100_7_lat", 32'(lat), 32'd34);
    chk("u100_7_busy", 32'(bcnt), 32'd33);
    chk("u100_7_quot", M_div_quot, 32'd14);
    chk_rem("u100_7_rem", 32'd2);
    tick();
    chk("done_drop", 32'(M_div_done), 32'd0);

    // Signed -100 / 7
    do_div(32'hFFFF_FF9C, 32'd7, 1'b1, lat, bcnt);
    chk("s_m100_7_quot", M_div_quot, 32'hFFFF_FFF2);
    chk_rem("s_m100_7_rem", 32'hFFFF_FFFE);

    // Signed overflow
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, bcnt);
    chk("ovf_quot", M_div_quot, 32'h8000_0000);
    chk_rem("ovf_rem", 32'd0);

    // Divide by zero, both modes
    do_div(32'h1234_5678, 32'd0, 1'b1, lat, bcnt);
    chk("dz_s_quot", M_div_quot, 32'hFFFF_FFFF);
    chk_rem("dz_s_rem", 32'h1234_5678);
    do_div(32'h1234_5678, 32'd0, 1'b0, lat, bcnt);
    chk("dz_u_quot", M_div_quot, 32'hFFFF_FFFF);
    chk_rem("dz_u_rem", 32'h1234_5678);

    // Back-to-back issue in the done cycle; a start during busy is ignored
    do_div(32'd100, 32'd7, 1'b0, lat, bcnt);
    chk("b2b_first_quot", M_div_quot, 32'd14);
    E_src1 = 32'hFFFF_FFFF;
    E_src2 = 32'h10;
    E_div_signed = 1'b0;
    E_div_start = 1'b1;
    lat = 0;
    held_bad = 0;
    do begin
      tick();
      E_div_start = 1'b0;
      lat++;
      if (lat == 5) begin
        E_src1 = 32'd5;
        E_src2 = 32'd1;
        E_div_signed = 1'b1;
        E_div_start = 1'b1;
      end
      if (!M_div_done && M_div_quot !== 32'd14) held_bad++;
    end while (!M_div_done && lat < 100);
    chk("b2b_held", 32'(held_bad), 32'd0);
    chk("b2b_lat", 32'(lat), 32'd34);
    chk("b2b_quot", M_div_quot, 32'h0FFF_FFFF);
    chk_rem("b2b_rem", 32'hF);
    tick();
    chk("b2b_no_requeue", 32'(M_div_busy), 32'd0);

    // M_en low for 5 cycles mid-DIV
    E_src1 = 32'd1000;
    E_src2 = 32'd3;
    E_div_signed = 1'b0;
    E_div_start = 1'b1;
    tick();
    E_div_start = 1'b0;
    lat = 1;
    repeat (9) begin tick(); lat++; end
    M_en = 1'b0;
    repeat (5) begin tick(); lat++; end
    chk("en_freeze_busy", 32'(M_div_busy), 32'd1);
    chk("en_freeze_done", 32'(M_div_done), 32'd0);
    M_en = 1'b1;
    while (!M_div_done && lat < 100) begin tick(); lat++; end
    chk("en_lat", 32'(lat), 32'd39);
    chk("en_quot", M_div_quot, 32'd333);
    chk_rem("en_rem", 32'd1);
    // Done held while disabled, dropped after the first enabled edge
    M_en = 1'b0;
    tick();
    tick();
    chk("done_hold", 32'(M_div_done), 32'd1);
    M_en = 1'b1;
    tick();
    chk("done_release", 32'(M_div_done), 32'd0);

    // Reset mid-operation
    E_src1 = 32'd77;
    E_src2 = 32'd5;
    E_div_start = 1'b1;
    tick();
    E_div_start = 1'b0;
    repeat (9) tick();
    reset_n = 1'b0;
    tick();
    chk("mid_rst_busy", 32'(M_div_busy), 32'd0);
    chk("mid_rst_done", 32'(M_div_done), 32'd0);
    chk("mid_rst_quot", M_div_quot, 32'd0);
    reset_n = 1'b1;
    done_seen = 0;
    repeat (40) begin
      tick();
      if (M_div_done) done_seen++;
    end
    chk("mid_rst_no_done", 32'(done_seen), 32'd0);

    // Randomized operands against the reference model
    for (int i = 0; i < 1000; i++) begin
      a   = $urandom;
      sgn = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 15));
        2: b = 32'(-$urandom_range(1, 15));
        3: b = ($urandom_range(0, 1) != 0) ? 32'd0 : 32'hFFFF_FFFF;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if ($urandom_range(0, 15) == 0) a = 32'h8000_0000;
      ref_div(a, b, sgn, eq, er);
      do_div(a, b, sgn, lat, bcnt);
      chk("rnd_lat", 32'(lat), 32'd34);
      chk("rnd_quot", M_div_quot, eq);
      chk_rem("rnd_rem", er);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
